camera_frame_reader: RTL and testbench

- HCLK-domain consumer of the camera capture stage.
- Requests one frame capture over the DATA_VALID/DATA_READY handshake, waits for the capture to complete and be released, then reads the dual-port frame RAM sequentially.
- Emits pixels on a valid/ready stream toward the AHB-side DMA/display path.
- Owns the only drive of the frame-RAM read port.

---
 rtl/camera_frame_reader.sv | 170 +++++++++++++++++
 tb/tb_camera_frame_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_frame_reader.sv
// camera_frame_reader: requests one camera capture, waits for its release, then streams the frame RAM.
// Define CAM_RD_PACK2_EN to pack two 16-bit pixels per output word.
module camera_frame_reader #(
  parameter int unsigned FRAME_PIXELS   = 76800,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16000000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  output logic [16:0] DualRAM_RADDR,
  input  logic [31:0] DualRAM_RDATA,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);

  localparam logic [17:0] READS = 18'(FRAME_PIXELS);

  typedef enum logic [1:0] {IDLE, REQ, REL, READ} state_t;

  state_t      state, state_nx;
  logic        sync1, rdy_s;
  logic [23:0] tmo_cnt;
  logic        timeout_hit;
  logic [17:0] rd_addr;
  logic        inflight, inflight_last;
  logic [1:0]  fifo_count;
  logic        wr_ptr, rd_ptr;
  logic [31:0] fifo_data [2];
  logic [1:0]  fifo_last;
  logic [2:0]  budget;
  logic        issue, push, pop, last_acc;
  logic [31:0] push_data;
  logic        unused_rdata;

  assign unused_rdata = ^DualRAM_RDATA[31:16];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1 <= 1'b0;
      rdy_s <= 1'b0;
    end else begin
      sync1 <= DATA_READY;
      rdy_s <= sync1;
    end
  end

  assign pix_valid   = (fifo_count != 2'd0);
  assign pix_data    = fifo_data[rd_ptr];
  assign pix_last    = fifo_last[rd_ptr];
  assign pop         = pix_valid & pix_ready;
  assign last_acc    = pop & pix_last;
  assign busy        = (state != IDLE);
  assign timeout_hit = (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

`ifdef CAM_RD_PACK2_EN
  logic        half;
  logic [15:0] pack_lo;

  // A half-filled pair occupies one slot of the two-word budget.
  assign budget    = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, inflight} + {2'b0, half};
  assign push      = inflight & half;
  assign push_data = {DualRAM_RDATA[15:0], pack_lo};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      half    <= 1'b0;
      pack_lo <= '0;
    end else if (state == REL) begin
      half <= 1'b0;
    end else if (inflight) begin
      half <= ~half;
      if (!half) pack_lo <= DualRAM_RDATA[15:0];
    end
  end
`else
  // A same-cycle pop frees its slot, sustaining one word per cycle.
  assign budget    = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, inflight};
  assign push      = inflight;
  assign push_data = {16'h0000, DualRAM_RDATA[15:0]};
`endif

  assign issue = (state == READ) && (rd_addr < READS) && (budget < 3'd2);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = REQ;
      REQ:     if (rdy_s) state_nx = REL;
               else if (timeout_hit) state_nx = IDLE;
      REL:     if (!rdy_s) state_nx = READ;
      READ:    if (last_acc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      DATA_VALID    <= 1'b0;
      err_timeout   <= 1'b0;
      tmo_cnt       <= '0;
      done          <= 1'b0;
      rd_addr       <= '0;
      DualRAM_RADDR <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done     <= last_acc;
      inflight <= issue;
      case (state)
        IDLE: if (start) begin
          DATA_VALID  <= 1'b1;
          tmo_cnt     <= '0;
          err_timeout <= 1'b0;
        end
        REQ: begin
          if (rdy_s) begin
            DATA_VALID <= 1'b0;
          end else if (timeout_hit) begin
            DATA_VALID  <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        REL: if (!rdy_s) rd_addr <= '0;
        READ: if (issue) begin
          DualRAM_RADDR <= rd_addr[16:0];
          rd_addr       <= rd_addr + 18'd1;
          inflight_last <= (rd_addr == READS - 18'd1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_last  <= '0;
      fifo_count <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_frame_reader.sv
// Bench for camera_frame_reader: camera handshake, RAM and stream sink driven from directed sequences,
// with a per-cycle monitor comparing the output stream against an index-based frame model.
module tb_camera_frame_reader;

  localparam int unsigned NPIX = 8;
`ifdef CAM_RD_PACK2_EN
  localparam int          WORDS  = 4;
  localparam int          LAT    = 6;
  localparam logic [31:0] FIRST_W = 32'h10011000;
  localparam logic [31:0] LAST_W  = 32'h10071006;
`else
  localparam int          WORDS  = 8;
  localparam int          LAT    = 5;
  localparam logic [31:0] FIRST_W = 32'h00001000;
  localparam logic [31:0] LAST_W  = 32'h00001007;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic        DATA_READY = 1'b0;
  logic        pix_ready = 1'b1;
  logic        DATA_VALID;
  logic [16:0] DualRAM_RADDR;
  logic [31:0] DualRAM_RDATA;
  logic [31:0] pix_data;
  logic        pix_valid, pix_last, busy, done, err_timeout;

  always #5 HCLK = ~HCLK;

  // Frame RAM: low half holds addr+0x1000, high half is junk that must never reach the stream.
  assign DualRAM_RDATA = {16'hA5A5, 16'h1000 + DualRAM_RADDR[15:0]};

  camera_frame_reader #(.FRAME_PIXELS(NPIX), .TIMEOUT_CYCLES(24'd50)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .DualRAM_RADDR(DualRAM_RADDR), .DualRAM_RDATA(DualRAM_RDATA),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  int          checks = 0;
  int          fails = 0;
  int          idx = 0;
  int          dones = 0;
  int          rcyc = 0;
  bit          mon_en = 1'b0;
  bit          rnd_ready = 1'b0;
  bit          last_prev = 1'b0;
  bit          held_v = 1'b0;
  logic [31:0] held_d;
  logic        held_l;
  logic [16:0] ra_prev = '0;
  logic [16:0] ra_next = '0;
  logic [31:0] got [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
`ifdef CAM_RD_PACK2_EN
    logic [15:0] lo;
    lo = 16'h1000 + 16'(2 * k);
    return {lo + 16'd1, lo};
`else
    return {16'h0000, 16'h1000 + 16'(k)};
`endif
  endfunction

  initial forever begin
    bit [3:0] pat;
    pat = 4'b1001;
    @(posedge HCLK); #1;
    rcyc++;
    if (rnd_ready) pix_ready = pat[rcyc % 4] ^ ($urandom_range(0, 3) == 0);
    else           pix_ready = 1'b1;
  end

  always @(negedge HCLK) if (mon_en) begin
    check("done", 32'(done), 32'(last_prev));
    if (done) dones++;
    if (held_v) begin
      check("stall_valid", 32'(pix_valid), 32'd1);
      check("stall_data", pix_data, held_d);
      check("stall_last", 32'(pix_last), 32'(held_l));
    end
    if (pix_valid && pix_ready) begin
      check("pix_data", pix_data, exp_word(idx));
      check("pix_last", 32'(pix_last), 32'(idx == WORDS - 1));
      if (idx < 16) got[idx] = pix_data;
      idx++;
    end
    last_prev = pix_valid && pix_ready && pix_last;
    held_v    = pix_valid && !pix_ready;
    held_d    = pix_data;
    held_l    = pix_last;
    if (DualRAM_RADDR != ra_prev) begin
      check("raddr_seq", 32'(DualRAM_RADDR), 32'(ra_next));
      ra_next = ra_next + 17'd1;
      ra_prev = DualRAM_RADDR;
    end
  end

  task automatic begin_frame();
    idx       = 0;
    dones     = 0;
    last_prev = 1'b0;
    held_v    = 1'b0;
    ra_next   = (ra_prev == 17'd0) ? 17'd1 : 17'd0;
  endtask

  task automatic pulse_start();
    @(posedge HCLK); #1 start = 1'b1;
    @(posedge HCLK); #1 start = 1'b0;
  endtask

  task automatic capture(input int rise_dly, input int hold, input bit quiet);
    int n;
    repeat (rise_dly) @(posedge HCLK);
    #1 DATA_READY = 1'b1;
    n = 0;
    while (DATA_VALID === 1'b1 && n < 10) begin
      @(posedge HCLK); #1;
      n++;
    end
    check("dv_fall_latency", 32'(n), 32'd3);
    repeat (hold) begin
      @(posedge HCLK); #1;
      if (quiet) begin
        check("quiet_valid", 32'(pix_valid), 32'd0);
        check("quiet_raddr", 32'(DualRAM_RADDR), 32'd7);
        check("quiet_busy", 32'(busy), 32'd1);
      end
    end
    DATA_READY = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge HCLK); #1;
      check("first_valid_latency", 32'(pix_valid), 32'(i >= LAT));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (dones == 0 && n < 300) begin
      @(posedge HCLK); #1;
      n++;
    end
    check("done_seen", 32'(dones != 0), 32'd1);
    repeat (3) @(posedge HCLK);
    #1;
    check("word_count", 32'(idx), 32'(WORDS));
    check("done_count", 32'(dones), 32'd1);
    check("raddr_end", 32'(DualRAM_RADDR), 32'd7);
    check("busy_end", 32'(busy), 32'd0);
    check("first_word", got[0], FIRST_W);
    check("last_word", got[WORDS - 1], LAST_W);
  endtask

  task automatic wait_words(input int k);
    int n;
    n = 0;
    while (idx < k && n < 100) begin
      @(posedge HCLK); #1;
      n++;
    end
    check("words_reached", 32'(idx >= k), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_data_valid", 32'(DATA_VALID), 32'd0);
    check("rst_raddr", 32'(DualRAM_RADDR), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", pix_data, 32'd0);
    check("rst_pix_last", 32'(pix_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    #2;
    check_reset_outputs();
    @(negedge HCLK);
    HRESETn = 1'b1;
    ra_prev = '0;
    mon_en  = 1'b1;

    // Test A: plain frame, sink always ready
    begin_frame();
    pulse_start();
    check("A_dv_high", 32'(DATA_VALID), 32'd1);
    check("A_busy", 32'(busy), 32'd1);
    capture(20, 5, 1'b0);
    wait_done();

    // Test B: sink stalls with a 1,0,0,1 pattern plus random flips
    rnd_ready = 1'b1;
    begin_frame();
    pulse_start();
    capture(20, 5, 1'b0);
    wait_done();
    rnd_ready = 1'b0;

    // Test E: camera holds DATA_READY high for 30 cycles after release
    begin_frame();
    pulse_start();
    capture(10, 30, 1'b1);
    wait_done();

    // Test C: no camera response, request times out after 50 cycles
    pulse_start();
    repeat (49) @(posedge HCLK);
    #1;
    check("C_dv_before_timeout", 32'(DATA_VALID), 32'd1);
    check("C_err_before_timeout", 32'(err_timeout), 32'd0);
    @(posedge HCLK); #1;
    check("C_dv_after_timeout", 32'(DATA_VALID), 32'd0);
    check("C_err_after_timeout", 32'(err_timeout), 32'd1);
    check("C_busy_after_timeout", 32'(busy), 32'd0);
    check("C_raddr_unchanged", 32'(DualRAM_RADDR), 32'd7);
    begin_frame();
    pulse_start();
    check("C_err_cleared", 32'(err_timeout), 32'd0);
    check("C_dv_restart", 32'(DATA_VALID), 32'd1);
    capture(20, 5, 1'b0);
    wait_done();

    // Test D: start during READ is ignored
    begin_frame();
    pulse_start();
    capture(20, 5, 1'b0);
    wait_words(1);
    pulse_start();
    check("D_dv_ignored_start", 32'(DATA_VALID), 32'd0);
    check("D_busy_during_read", 32'(busy), 32'd1);
    wait_done();

    // Test D: reset mid-READ, then a clean frame
    begin_frame();
    pulse_start();
    capture(20, 5, 1'b0);
    wait_words(2);
    check("D_busy_before_reset", 32'(busy), 32'd1);
    #3;
    mon_en  = 1'b0;
    HRESETn = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge HCLK); @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    ra_prev = '0;
    begin_frame();
    mon_en = 1'b1;
    pulse_start();
    capture(20, 5, 1'b0);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
